// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one binary bit per clock,
// with valid/ready on both sides and a leading-zero blanking mask.

module bin2bcd_seq_dig (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);
  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;
endmodule

module bin2bcd_seq #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  // 10^DIGITS > 2^WIDTH-1  <=>  all-ones divided by 10 DIGITS times reaches zero.
  function automatic bit digits_fit();
    logic [WIDTH+3:0] v;
    v = {4'd0, {WIDTH{1'b1}}};
    for (int i = 0; i < DIGITS; i++) v = v / (WIDTH+4)'(10);
    return v == '0;
  endfunction

  if (WIDTH < 1 || DIGITS < 1) begin : g_bad_size
    $error("bin2bcd_seq: WIDTH and DIGITS must be >= 1");
  end
  if (!digits_fit()) begin : g_bad_digits
    $error("bin2bcd_seq: DIGITS too small to hold 2^WIDTH-1");
  end

  localparam int CW = $clog2(WIDTH + 1);
  localparam int AW = 4 * DIGITS;
  localparam logic [DIGITS-1:0] BLANK_RST = ~(DIGITS'(1));

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state, w_state_nx;
  logic [WIDTH-1:0]  r_bin;
  logic [AW-1:0]     r_acc;
  logic [CW-1:0]     r_cnt;
  logic [AW-1:0]     r_bcd;
  logic [DIGITS-1:0] r_blank;

  logic [AW-1:0]       w_adj;
  logic [AW+WIDTH-1:0] w_cat;
  logic [AW-1:0]       w_acc_nx;
  logic [WIDTH-1:0]    w_bin_nx;
  logic [DIGITS-1:0]   w_blank;
  logic                w_last;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dig
    bin2bcd_seq_dig u_dig (
      .i_d (r_acc[4*i +: 4]),
      .o_d (w_adj[4*i +: 4])
    );
    // Digit i blanks when it and every digit above it are zero; units never blank.
    if (i == 0) begin : g_units
      assign w_blank[i] = 1'b0;
    end else begin : g_upper
      assign w_blank[i] = (w_acc_nx[AW-1:4*i] == '0);
    end
  end

  assign w_cat    = {w_adj, r_bin} << 1;
  assign w_acc_nx = w_cat[AW+WIDTH-1 -: AW];
  assign w_bin_nx = w_cat[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    w_last     = 1'b0;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_state_nx = S_SHIFT;
      S_SHIFT: begin
        w_last = (r_cnt == CW'(WIDTH - 1));
        if (w_last) w_state_nx = S_DONE;
      end
      S_DONE:  if (out_ready) w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin   <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_blank <= BLANK_RST;
    end else begin
      unique case (r_state)
        S_IDLE: if (in_valid) begin
          r_bin <= x;
          r_acc <= '0;
          r_cnt <= '0;
        end
        S_SHIFT: begin
          r_bin <= w_bin_nx;
          r_acc <= w_acc_nx;
          r_cnt <= r_cnt + 1'b1;
          if (w_last) begin
            r_bcd   <= w_acc_nx;
            r_blank <= w_blank;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign bcd       = r_bcd;
  assign blank     = r_blank;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 16/5, 8/3 and 1/1 instances checked against a
// decimal reference model built from div/mod arithmetic.

module tb_bin2bcd_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        iv16, ir16, ov16, or16;
  logic [15:0] x16;
  logic [19:0] bcd16;
  logic [4:0]  bl16;

  logic        iv8, ir8, ov8, or8;
  logic [7:0]  x8;
  logic [11:0] bcd8;
  logic [2:0]  bl8;

  logic        iv1, ir1, ov1, or1;
  logic [0:0]  x1;
  logic [3:0]  bcd1;
  logic [0:0]  bl1;

  int errors = 0;
  int checks = 0;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) u16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .x(x16),
    .out_valid(ov16), .out_ready(or16), .bcd(bcd16), .blank(bl16));

  bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .x(x8),
    .out_valid(ov8), .out_ready(or8), .bcd(bcd8), .blank(bl8));

  bin2bcd_seq #(.WIDTH(1), .DIGITS(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .x(x1),
    .out_valid(ov1), .out_ready(or1), .bcd(bcd1), .blank(bl1));

  function automatic logic [19:0] ref_bcd(input int unsigned v, input int nd);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_blank(input int unsigned v, input int nd);
    logic [4:0]  b;
    int unsigned p;
    b = '0;
    p = 1;
    for (int i = 1; i < nd; i++) begin
      p = p * 10;
      b[i] = (v < p);
    end
    return b;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    checks++;
    if (ir16 !== 1'b0 || ir8 !== 1'b0 || ir1 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready got %b%b%b exp 000", ir16, ir8, ir1);
    end
    checks++;
    if (ov16 !== 1'b0 || bcd16 !== 20'h0 || bl16 !== 5'b11110) begin
      errors++; $display("FAIL reset_out16 got ov=%b bcd=%h bl=%b exp ov=0 bcd=00000 bl=11110", ov16, bcd16, bl16);
    end
    checks++;
    if (ov8 !== 1'b0 || bcd8 !== 12'h0 || bl8 !== 3'b110 || bl1 !== 1'b0) begin
      errors++; $display("FAIL reset_out8 got ov=%b bcd=%h bl=%b bl1=%b exp 0 000 110 0", ov8, bcd8, bl8, bl1);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ir16 !== 1'b1 || ir8 !== 1'b1 || ir1 !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b%b%b exp 111", ir16, ir8, ir1);
    end
  endtask

  task automatic test_latency8();
    int n;
    x8 = 8'd255; iv8 = 1'b1; or8 = 1'b1;
    cyc();
    iv8 = 1'b0; x8 = 8'd17;
    n = 0;
    while (!ov8 && n < 40) begin cyc(); n++; end
    checks++;
    if (n !== 8) begin errors++; $display("FAIL lat8 got %0d edges exp 8", n); end
    checks++;
    if (bcd8 !== 12'h255 || bl8 !== 3'b000) begin
      errors++; $display("FAIL lat8_val got bcd=%h bl=%b exp 255 000", bcd8, bl8);
    end
    cyc();
    checks++;
    if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
      errors++; $display("FAIL lat8_ret got ov=%b ir=%b exp 0 1", ov8, ir8);
    end
  endtask

  task automatic test_values16();
    int unsigned vals[$];
    logic [19:0] eb;
    logic [4:0]  ebl;
    int n;
    vals = '{65535, 0, 1000, 9999, 10000, 1};
    for (int i = 0; i < 20; i++) vals.push_back($urandom_range(0, 65535));
    or16 = 1'b1;
    foreach (vals[k]) begin
      x16 = 16'(vals[k]); iv16 = 1'b1;
      cyc();
      iv16 = 1'b0; x16 = 16'($urandom);
      n = 0;
      while (!ov16 && n < 40) begin cyc(); n++; end
      eb  = ref_bcd(vals[k], 5);
      ebl = ref_blank(vals[k], 5);
      checks++;
      if (n !== 16) begin errors++; $display("FAIL lat16 x=%0d got %0d exp 16", vals[k], n); end
      checks++;
      if (bcd16 !== eb || bl16 !== ebl) begin
        errors++; $display("FAIL val16 x=%0d got bcd=%h bl=%b exp bcd=%h bl=%b", vals[k], bcd16, bl16, eb, ebl);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    int n;
    x16 = 16'd123; iv16 = 1'b1; or16 = 1'b0;
    cyc();
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 40) begin cyc(); n++; end
    x16 = 16'd9; iv16 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ov16 !== 1'b1 || bcd16 !== 20'h00123 || ir16 !== 1'b0) begin
        errors++; $display("FAIL bp_hold cyc=%0d got ov=%b bcd=%h ir=%b exp 1 00123 0", i, ov16, bcd16, ir16);
      end
      cyc();
    end
    or16 = 1'b1;
    cyc();
    checks++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b exp 0 1", ov16, ir16);
    end
    cyc();
    iv16 = 1'b0; x16 = 16'd7777;
    checks++;
    if (ir16 !== 1'b0) begin errors++; $display("FAIL bp_accept got ir=%b exp 0", ir16); end
    n = 0;
    while (!ov16 && n < 40) begin cyc(); n++; end
    checks++;
    if (n !== 16 || bcd16 !== 20'h00009 || bl16 !== 5'b11110) begin
      errors++; $display("FAIL bp_second got n=%0d bcd=%h bl=%b exp 16 00009 11110", n, bcd16, bl16);
    end
    cyc();
  endtask

  task automatic test_reset_mid();
    int n;
    x16 = 16'd4321; iv16 = 1'b1; or16 = 1'b1;
    cyc();
    iv16 = 1'b0;
    repeat (5) cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    checks++;
    if (ov16 !== 1'b0 || bcd16 !== 20'h0 || bl16 !== 5'b11110 || ir16 !== 1'b1) begin
      errors++; $display("FAIL rstmid got ov=%b bcd=%h bl=%b ir=%b exp 0 00000 11110 1", ov16, bcd16, bl16, ir16);
    end
    x16 = 16'd42; iv16 = 1'b1;
    cyc();
    iv16 = 1'b0;
    n = 0;
    while (!ov16 && n < 40) begin cyc(); n++; end
    checks++;
    if (n !== 16 || bcd16 !== 20'h00042 || bl16 !== 5'b11100) begin
      errors++; $display("FAIL rstmid_42 got n=%0d bcd=%h bl=%b exp 16 00042 11100", n, bcd16, bl16);
    end
    cyc();
  endtask

  task automatic test_exhaustive8();
    int unsigned q[$];
    int unsigned v;
    int next, done, last, cnt;
    bit acc;
    logic [19:0] eb;
    logic [4:0]  ebl;
    next = 0; done = 0; last = -1; cnt = 0;
    x8 = 8'd0; iv8 = 1'b1; or8 = 1'b1;
    while (done < 256 && cnt < 3000) begin
      acc = ir8 && iv8;
      if (ov8) begin
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL ex8_spurious got out_valid=1 exp no pending result");
        end else begin
          v = q.pop_front();
          eb = ref_bcd(v, 3); ebl = ref_blank(v, 3);
          if (bcd8 !== eb[11:0] || bl8 !== ebl[2:0]) begin
            errors++; $display("FAIL ex8 x=%0d got bcd=%h bl=%b exp bcd=%h bl=%b", v, bcd8, bl8, eb[11:0], ebl[2:0]);
          end
        end
        done++;
      end
      cyc(); cnt++;
      if (acc) begin
        q.push_back(next);
        if (last >= 0) begin
          checks++;
          if (cnt - last !== 10) begin
            errors++; $display("FAIL ex8_rate x=%0d got %0d exp 10", next, cnt - last);
          end
        end
        last = cnt;
        next++;
        x8 = 8'(next);
        if (next == 256) iv8 = 1'b0;
      end
    end
    iv8 = 1'b0;
    checks++;
    if (done !== 256) begin errors++; $display("FAIL ex8_count got %0d exp 256", done); end
  endtask

  task automatic test_width1();
    int n;
    or1 = 1'b1;
    for (int v = 1; v >= 0; v--) begin
      x1 = 1'(v); iv1 = 1'b1;
      cyc();
      iv1 = 1'b0; x1 = ~x1;
      n = 0;
      while (!ov1 && n < 10) begin cyc(); n++; end
      checks++;
      if (n !== 1 || bcd1 !== 4'(v) || bl1 !== 1'b0) begin
        errors++; $display("FAIL w1 x=%0d got n=%0d bcd=%h bl=%b exp 1 %0d 0", v, n, bcd1, bl1, v);
      end
      cyc();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iv16 = 1'b0; or16 = 1'b0; x16 = '0;
    iv8  = 1'b0; or8  = 1'b0; x8  = '0;
    iv1  = 1'b0; or1  = 1'b0; x1  = '0;
    test_reset();
    cyc();
    test_latency8();
    test_values16();
    test_backpressure();
    test_reset_mid();
    test_exhaustive8();
    test_width1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
